// File: rtl/sdram_port_arbiter_if.sv
// Handshake bundle between the port arbiter (slave) and its environment (master):
// FIFO empty flags, SDRAM FSM done/ref_ack pulses, and the grant/refresh outputs.
interface sdram_port_arbiter_if;
  logic [15:0] fifo_empty;
  logic        done;
  logic        ref_ack;
  logic [3:0]  fifo_sel;
  logic        tx_fifo_empty;
  logic        ref_req;
  logic        grant_valid;
  logic        ref_overrun;

  modport slave (
    input  fifo_empty, done, ref_ack,
    output fifo_sel, tx_fifo_empty, ref_req, grant_valid, ref_overrun
  );

  modport master (
    output fifo_empty, done, ref_ack,
    input  fifo_sel, tx_fifo_empty, ref_req, grant_valid, ref_overrun
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin scheduler of port Tx FIFOs onto the SDRAM command FSM, with periodic refresh.
// Optional macro VMC_ARB_PORT0_PRIO_EN: port 0 (CPU) wins over round-robin ports 1..NR_PORTS-1.
//
// state   | meaning
// IDLE    | no grant; picks refresh (priority) or next non-empty port
// GRANT   | port fifo_sel owns the FSM until done
// REFRESH | ref_req asserted, waiting for ref_ack
module sdram_port_arbiter #(
  parameter int NR_PORTS     = 4,
  parameter int REF_INTERVAL = 390,
  parameter int REF_CNT_W    = 10
) (
  input  logic                  sdram_clk_0,
  input  logic                  wb_rst,
  sdram_port_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {IDLE, GRANT, REFRESH} state_t;

  localparam logic [REF_CNT_W-1:0] REF_RELOAD = REF_CNT_W'(REF_INTERVAL - 1);
  localparam logic [3:0]           RR_RESET   = 4'(NR_PORTS - 1);

  state_t               state, state_nxt;
  logic [REF_CNT_W-1:0] ref_cnt;
  logic                 ref_pending;
  logic                 ref_expire;
  logic                 ref_clr;
  logic [3:0]           rr_ptr;
  logic [3:0]           fifo_sel_q;
  logic                 ref_req_q;
  logic                 grant_valid_q;
  logic                 ref_overrun_q;
  logic                 pick_valid;
  logic [3:0]           pick_idx;
  logic [4:0]           cand;

  assign ref_expire = (ref_cnt == '0);
  assign ref_clr    = (state == REFRESH) && arb.ref_ack;

  // Search starts one past the last granted port and wraps at NR_PORTS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 4'd0;
    cand       = 5'd0;
    for (int i = 1; i <= NR_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + 5'(i);
      if (cand >= 5'(NR_PORTS))
        cand = cand - 5'(NR_PORTS);
      if (!pick_valid && !arb.fifo_empty[cand[3:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
`ifdef VMC_ARB_PORT0_PRIO_EN
    if (!arb.fifo_empty[0]) begin
      pick_valid = 1'b1;
      pick_idx   = 4'd0;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ref_pending)
          state_nxt = REFRESH;
        else if (pick_valid)
          state_nxt = GRANT;
      end
      GRANT:   if (arb.done)    state_nxt = IDLE;
      REFRESH: if (arb.ref_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk_0 or posedge wb_rst) begin
    if (wb_rst) begin
      state         <= IDLE;
      ref_cnt       <= REF_RELOAD;
      ref_pending   <= 1'b0;
      ref_overrun_q <= 1'b0;
      rr_ptr        <= RR_RESET;
      fifo_sel_q    <= 4'd0;
      ref_req_q     <= 1'b0;
      grant_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;

      ref_cnt <= ref_expire ? REF_RELOAD : ref_cnt - 1'b1;

      // A new expiry wins over a same-cycle ack and is not an overrun.
      if (ref_expire)
        ref_pending <= 1'b1;
      else if (ref_clr)
        ref_pending <= 1'b0;
      if (ref_expire && ref_pending && !ref_clr)
        ref_overrun_q <= 1'b1;

      if (state == IDLE && state_nxt == GRANT) begin
        fifo_sel_q    <= pick_idx;
        grant_valid_q <= 1'b1;
      end
      if (state == IDLE && state_nxt == REFRESH)
        ref_req_q <= 1'b1;
      if (ref_clr)
        ref_req_q <= 1'b0;

      if (state == GRANT && arb.done) begin
        grant_valid_q <= 1'b0;
`ifdef VMC_ARB_PORT0_PRIO_EN
        if (fifo_sel_q != 4'd0)
          rr_ptr <= fifo_sel_q;
`else
        rr_ptr <= fifo_sel_q;
`endif
      end
    end
  end

  // Combinational so the FSM sees a FIFO running dry mid-burst.
  assign arb.tx_fifo_empty = (state == GRANT) ? arb.fifo_empty[fifo_sel_q] : 1'b1;
  assign arb.fifo_sel      = fifo_sel_q;
  assign arb.ref_req       = ref_req_q;
  assign arb.grant_valid   = grant_valid_q;
  assign arb.ref_overrun   = ref_overrun_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Scheduler between the per-port Tx FIFOs of the wishbone clock domains and the single SDRAM command FSM (sdr_16/ddr_16).
- Generates the periodic refresh request.
- Picks one non-empty port FIFO round-robin and presents it as fifo_sel / tx_fifo_empty.
- Holds the grant until the FSM signals transaction completion with done.
- Refresh is never started while a grant is active.

Parameters:
NR_PORTS, 4, number of active port FIFOs (1..16); ports NR_PORTS..15 are ignored.
REF_INTERVAL, 390, sdram_clk_0 cycles between refresh requests (7.8 us at 50 MHz).
REF_CNT_W, 10, width of the refresh down-counter; must satisfy 2**REF_CNT_W > REF_INTERVAL.

Ports:
sdram_clk_0  in  1  SDRAM-side clock; all state on rising edge.
wb_rst  in  1  reset, asynchronous, active-high.
fifo_empty  in  16  per-port Tx FIFO empty flags, bit n = port n; unused bits tied 1 by the top level.
done  in  1  single-cycle pulse from the FSM: granted transaction (incl. burst) finished.
ref_ack  in  1  single-cycle pulse from the FSM: refresh command issued.
fifo_sel  out  4  binary index of the granted port.
tx_fifo_empty  out  1  empty flag seen by the FSM.
ref_req  out  1  refresh request to the FSM.
grant_valid  out  1  a port is currently granted.
ref_overrun  out  1  sticky: a refresh interval expired while the previous refresh was still pending.

Behaviour:
Reset values: fifo_sel=0, tx_fifo_empty=1, ref_req=0, grant_valid=0, ref_overrun=0, rr_ptr=NR_PORTS-1, ref_cnt=REF_INTERVAL-1, ref_pending=0, state=IDLE.

Refresh timer:
- ref_cnt decrements every cycle.
- At 0 it reloads REF_INTERVAL-1 and sets ref_pending.
- If ref_pending is already 1 at expiry, ref_overrun is set; it is cleared only by reset.

State machine, states IDLE, GRANT, REFRESH:
- IDLE, ref_pending=1: go to REFRESH. Refresh has priority over any port.
- IDLE, ref_pending=0, any valid port non-empty: go to GRANT.
  - fifo_sel = first n with fifo_empty[n]=0, searching (rr_ptr+1) mod NR_PORTS upward with wrap.
  - grant_valid=1 from the next cycle. Latency from FIFO going non-empty to grant_valid: 1 cycle.
- IDLE otherwise: stay; tx_fifo_empty=1.
- GRANT:
  - fifo_sel is held constant.
  - tx_fifo_empty = fifo_empty[fifo_sel], combinational, so the FSM sees mid-burst emptiness.
  - On done=1: rr_ptr<=fifo_sel, grant_valid<=0, go to IDLE. A new grant requires at least one IDLE cycle.
  - A refresh expiry during GRANT only sets ref_pending; the grant is never preempted.
- REFRESH:
  - ref_req=1 (registered) and tx_fifo_empty=1.
  - On ref_ack=1: clear ref_pending, ref_req<=0, go to IDLE.
  - If the timer expires in the same cycle as ref_ack, ref_pending stays 1 (set wins over clear) and ref_overrun is not set.
- Spurious inputs: done outside GRANT and ref_ack outside REFRESH are ignored.
- Only one port with data: it is re-granted each time, with 1 IDLE cycle between grants.
- Reset mid-operation: all state returns to reset values immediately (async); any in-flight grant or refresh is abandoned.

Optional Feature:
Macro VMC_ARB_PORT0_PRIO_EN.
- Defined: in IDLE with no refresh pending, port 0 non-empty always wins. Round-robin applies only among ports 1..NR_PORTS-1, and rr_ptr is updated only by grants to ports 1..NR_PORTS-1. This is the low-latency CPU port.
- Undefined: pure round-robin over all ports as above.

Test Plan:
- Reset release, all fifo_empty=16'hFFFF -> outputs stay at reset values; ref_req rises at cycle 391 after reset.
- NR_PORTS=4, ports 1 and 3 non-empty, done pulsed 5 cycles after each grant -> fifo_sel sequence 1,3,1,3; grant_valid low exactly 1 cycle between grants.
- Refresh expires while port 2 is granted -> ref_req stays 0 until done; REFRESH is entered next; after ref_ack, port 2 is granted again in IDLE if still non-empty.
- ref_ack withheld for 400 cycles -> ref_overrun=1 at the second expiry and stays 1 until wb_rst.
- ref_ack in the same cycle as timer expiry -> ref_req reasserts 2 cycles later; ref_overrun remains 0.
- With VMC_ARB_PORT0_PRIO_EN, ports 0,1,2 always non-empty -> grants 0,0,0...; drain port 0 -> grants alternate 1,2,1,2.
